// File: rtl/icache_nway_if.sv
// Fetch-side and refill-memory-side signals of the set-associative I-cache.
// slave is the cache's view; master is the core/memory side driving it.
interface icache_nway_if;
  logic [31:0] i_addr;
  logic        i_req;
  logic [31:0] o_rdata;
  logic        o_hit;
  logic        i_flush;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] i_mem_rdata;
  logic        i_mem_vd;
  logic        o_busy;
  logic [31:0] o_miss_count;

  modport slave (
    input  i_addr, i_req, i_flush, i_mem_rdata, i_mem_vd,
    output o_rdata, o_hit, o_mem_req, o_mem_addr, o_busy, o_miss_count
  );

  modport master (
    output i_addr, i_req, i_flush, i_mem_rdata, i_mem_vd,
    input  o_rdata, o_hit, o_mem_req, o_mem_addr, o_busy, o_miss_count
  );
endinterface

// File: rtl/icache_nway.sv
// Set-associative instruction cache. The lookup is combinational so o_hit can
// stall fetch in the same cycle. A miss starts a multi-word line refill, and
// victims are chosen round-robin, one pointer per set.
module icache_nway #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16,
  parameter int WAYS       = 2
) (
  input  logic          clk,
  input  logic          rst,
  icache_nway_if.slave  bus
);
  localparam int OFFW   = $clog2(LINE_WORDS * 4);
  localparam int WSW    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int IDXW   = $clog2(SETS);
  localparam int TAGW   = 32 - OFFW - IDXW;
  localparam int VPW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int NWORDS = SETS * WAYS * LINE_WORDS;
  localparam int DAW    = $clog2(NWORDS);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_DONE} state_t;

  state_t                                 state_q;
  logic [SETS-1:0][WAYS-1:0]              valid_q;
  logic [SETS-1:0][WAYS-1:0][TAGW-1:0]    tags_q;
  logic [SETS-1:0][VPW-1:0]               vptr_q;
  logic [31:0]                            data_q [NWORDS];

  logic [IDXW-1:0] lidx_q;
  logic [TAGW-1:0] ltag_q;
  logic [VPW-1:0]  vic_q;
  logic [WSW-1:0]  k_q;
  logic            mem_req_q;
  logic [31:0]     mem_addr_q;
  logic            busy_q;
  logic [31:0]     miss_q;

  // Address split of the current fetch address.
  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag;
  logic [WSW-1:0]  wsel;
  logic            unused_addr;

  assign idx         = bus.i_addr[OFFW+IDXW-1:OFFW];
  assign tag         = bus.i_addr[31:OFFW+IDXW];
  assign unused_addr = ^bus.i_addr[1:0];

  if (LINE_WORDS > 1) begin : g_wsel
    assign wsel = bus.i_addr[OFFW-1:2];
  end else begin : g_nowsel
    assign wsel = '0;
  end

  // Flat data-array address: set, then way, then word within the line.
  function automatic logic [DAW-1:0] dix(input logic [IDXW-1:0] s, input int w,
                                         input logic [WSW-1:0] k);
    int t;
    t = (int'(s) * WAYS + w) * LINE_WORDS + int'(k);
    return t[DAW-1:0];
  endfunction

  // Per-way tag compare in the indexed set.
  logic [WAYS-1:0] match;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign match[w] = valid_q[idx][w] && (tags_q[idx][w] == tag);
  end

  // Select the word of the matching way. At most one way matches because
  // the victim is invalidated before its refill starts.
  logic [31:0] rd_any;
  always_comb begin
    rd_any = '0;
    for (int w = 0; w < WAYS; w++)
      if (match[w]) rd_any = rd_any | data_q[dix(idx, w, wsel)];
  end

  logic hit;
  assign hit         = bus.i_req & (|match);
  assign bus.o_hit   = hit;
  assign bus.o_rdata = hit ? rd_any : '0;

  // Victim: lowest invalid way of the set, otherwise its round-robin pointer.
  logic [VPW-1:0] vic_d;
  logic           found;
  always_comb begin
    vic_d = vptr_q[idx];
    found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[idx][w]) begin
        vic_d = w[VPW-1:0];
        found = 1'b1;
      end
    end
  end

  // Refill control, valid/tag/pointer state and the registered memory-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      tags_q     <= '0;
      vptr_q     <= '0;
      lidx_q     <= '0;
      ltag_q     <= '0;
      vic_q      <= '0;
      k_q        <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      miss_q     <= '0;
    end else if (bus.i_flush) begin
      // A flush aborts any refill. The partial line was already invalidated.
      state_q   <= S_IDLE;
      valid_q   <= '0;
      vptr_q    <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_req && !hit) begin
            lidx_q              <= idx;
            ltag_q              <= tag;
            vic_q               <= vic_d;
            valid_q[idx][vic_d] <= 1'b0;
            k_q                 <= '0;
            mem_req_q           <= 1'b1;
            mem_addr_q          <= {bus.i_addr[31:OFFW], {OFFW{1'b0}}};
            busy_q              <= 1'b1;
            if (miss_q != '1) miss_q <= miss_q + 32'd1;
            state_q             <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_req_q && bus.i_mem_vd) begin
            if (k_q == WSW'(LINE_WORDS - 1)) begin
              mem_req_q <= 1'b0;
              state_q   <= S_DONE;
            end else begin
              k_q        <= k_q + 1'b1;
              mem_addr_q <= mem_addr_q + 32'd4;
            end
          end
        end
        S_DONE: begin
          valid_q[lidx_q][vic_q] <= 1'b1;
          tags_q[lidx_q][vic_q]  <= ltag_q;
          if (WAYS > 1 && vic_q == vptr_q[lidx_q])
            vptr_q[lidx_q] <= vptr_q[lidx_q] + 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Data array: each refill beat writes one word of the victim line.
  logic we;
  assign we = (state_q == S_REFILL) && mem_req_q && bus.i_mem_vd && !bus.i_flush;

  // Data write port. The array has no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (we) data_q[dix(lidx_q, int'(vic_q), k_q)] <= bus.i_mem_rdata;
  end

  assign bus.o_mem_req    = mem_req_q;
  assign bus.o_mem_addr   = mem_addr_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_miss_count = miss_q;
endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (4 words/line, 16 sets, 2 ways).
// Inputs change on the falling edge and outputs are sampled there too.
module tb_icache_nway;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_nway_if bus();

  icache_nway #(.LINE_WORDS(4), .SETS(16), .WAYS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  typedef struct {
    int          ph;
    logic [31:0] addr;
    logic        hit;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[15];

  // Present one fetch for 1 ns, check the combinational result, then withdraw it.
  task automatic probe(input logic [31:0] a, input logic h, input logic [31:0] d);
    @(negedge clk);
    bus.i_addr = a;
    bus.i_req  = 1'b1;
    #1;
    chk($sformatf("hit@%h", a), 32'(bus.o_hit), 32'(h));
    chk($sformatf("rdata@%h", a), bus.o_rdata, d);
    bus.i_req = 1'b0;
    #1;
  endtask

  task automatic run_phase(input int p);
    for (int i = 0; i < 15; i++)
      if (tbl[i].ph == p) probe(tbl[i].addr, tbl[i].hit, tbl[i].data);
  endtask

  // Raise a missing fetch for one edge. The first refill request must follow.
  task automatic start_miss(input logic [31:0] a);
    @(negedge clk);
    bus.i_addr = a;
    bus.i_req  = 1'b1;
    #1;
    chk($sformatf("miss@%h", a), 32'(bus.o_hit), 32'd0);
    @(negedge clk);
    bus.i_req = 1'b0;
    chk("req_after_miss", 32'(bus.o_mem_req), 32'd1);
    chk("busy_after_miss", 32'(bus.o_busy), 32'd1);
  endtask

  // Serve refill words k0..k1-1, with 'waits' idle cycles before each beat.
  task automatic do_words(input logic [31:0] base, input logic [31:0] dbase,
                          input int k0, input int k1, input int waits);
    for (int k = k0; k < k1; k++) begin
      for (int w = 0; w < waits; w++) begin
        chk($sformatf("hold_addr k%0d", k), bus.o_mem_addr, base + 32'(4 * k));
        chk($sformatf("hold_req k%0d", k), 32'(bus.o_mem_req), 32'd1);
        @(negedge clk);
      end
      chk($sformatf("mem_addr k%0d", k), bus.o_mem_addr, base + 32'(4 * k));
      chk($sformatf("mem_req k%0d", k), 32'(bus.o_mem_req), 32'd1);
      bus.i_mem_vd    = 1'b1;
      bus.i_mem_rdata = dbase + 32'(k);
      @(negedge clk);
      bus.i_mem_vd    = 1'b0;
      bus.i_mem_rdata = 32'h0;
    end
  endtask

  // After the last beat: one DONE cycle (request low, still busy), then idle.
  task automatic finish_refill();
    chk("done_req", 32'(bus.o_mem_req), 32'd0);
    chk("done_busy", 32'(bus.o_busy), 32'd1);
    @(negedge clk);
    chk("idle_busy", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1, 32'h108, 1'b1, 32'hA2};
    tbl[1]  = '{1, 32'h100, 1'b1, 32'hA0};
    tbl[2]  = '{1, 32'h10C, 1'b1, 32'hA3};
    tbl[3]  = '{1, 32'h110, 1'b0, 32'h0};
    tbl[4]  = '{1, 32'h200, 1'b0, 32'h0};
    tbl[5]  = '{2, 32'h100, 1'b0, 32'h0};
    tbl[6]  = '{2, 32'h104, 1'b0, 32'h0};
    tbl[7]  = '{2, 32'h200, 1'b1, 32'hB0};
    tbl[8]  = '{2, 32'h20C, 1'b1, 32'hB3};
    tbl[9]  = '{2, 32'h300, 1'b1, 32'hC0};
    tbl[10] = '{2, 32'h308, 1'b1, 32'hC2};
    tbl[11] = '{3, 32'h200, 1'b0, 32'h0};
    tbl[12] = '{3, 32'h300, 1'b0, 32'h0};
    tbl[13] = '{3, 32'h400, 1'b0, 32'h0};
    tbl[14] = '{3, 32'h404, 1'b0, 32'h0};

    rst             = 1'b0;
    bus.i_addr      = 32'h100;
    bus.i_req       = 1'b1;
    bus.i_flush     = 1'b0;
    bus.i_mem_rdata = 32'h0;
    bus.i_mem_vd    = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst_hit", 32'(bus.o_hit), 32'd0);
    chk("rst_rdata", bus.o_rdata, 32'd0);
    chk("rst_mem_req", 32'(bus.o_mem_req), 32'd0);
    chk("rst_mem_addr", bus.o_mem_addr, 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_miss", bus.o_miss_count, 32'd0);
    bus.i_req = 1'b0;
    rst       = 1'b1;
    @(negedge clk);

    // First line fill.
    start_miss(32'h100);
    do_words(32'h100, 32'hA0, 0, 4, 0);
    finish_refill();
    run_phase(1);
    chk("miss_cnt1", bus.o_miss_count, 32'd1);
    bus.i_addr = 32'h108;
    #1;
    chk("hit_needs_req", 32'(bus.o_hit), 32'd0);

    // Second way of set 0, with hits served while the refill is in progress.
    start_miss(32'h200);
    do_words(32'h200, 32'hB0, 0, 2, 0);
    probe(32'h104, 1'b1, 32'hA1);
    probe(32'h200, 1'b0, 32'h0);
    chk("busy_under_hit", 32'(bus.o_busy), 32'd1);
    do_words(32'h200, 32'hB0, 2, 4, 0);
    finish_refill();

    // Third tag in set 0 evicts way 0. Three wait states precede each beat.
    start_miss(32'h300);
    do_words(32'h300, 32'hC0, 0, 4, 3);
    finish_refill();
    run_phase(2);
    chk("miss_cnt3", bus.o_miss_count, 32'd3);

    // Flush after word 1 of the 0x400 refill, then send a stray beat.
    start_miss(32'h400);
    do_words(32'h400, 32'hD0, 0, 2, 0);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    chk("flush_req", 32'(bus.o_mem_req), 32'd0);
    chk("flush_busy", 32'(bus.o_busy), 32'd0);
    bus.i_mem_vd    = 1'b1;
    bus.i_mem_rdata = 32'hDEAD;
    @(negedge clk);
    bus.i_mem_vd    = 1'b0;
    chk("stray_req", 32'(bus.o_mem_req), 32'd0);
    chk("stray_busy", 32'(bus.o_busy), 32'd0);
    run_phase(3);
    chk("miss_cnt4", bus.o_miss_count, 32'd4);

    // Asynchronous reset between clock edges, in the middle of a refill.
    start_miss(32'h200);
    do_words(32'h200, 32'hE0, 0, 1, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_req", 32'(bus.o_mem_req), 32'd0);
    chk("arst_busy", 32'(bus.o_busy), 32'd0);
    chk("arst_miss", bus.o_miss_count, 32'd0);
    bus.i_addr = 32'h100;
    bus.i_req  = 1'b1;
    #1;
    chk("arst_hit", 32'(bus.o_hit), 32'd0);
    bus.i_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    start_miss(32'h100);
    do_words(32'h100, 32'hF0, 0, 4, 0);
    finish_refill();
    probe(32'h108, 1'b1, 32'hF2);
    chk("miss_cnt_after_rst", bus.o_miss_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
Parametrised set-associative instruction cache that sits between the core's fetch PC and the instruction memory port. It is the successor to the direct single-word fetch cache: line size, set count and associativity are configurable, and misses trigger a multi-word line refill FSM. It also provides a flush input and a miss counter. Lookup is combinational, so `o_hit` can drive the fetch stall in the same cycle the PC is presented.

Parameters:
- `LINE_WORDS`, 4: 32-bit words per line; power of 2, ≥1.
- `SETS`, 16: number of sets; power of 2, ≥2.
- `WAYS`, 2: associativity; power of 2, 1..8.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `i_addr`  in  32  fetch address; bits[1:0] ignored.
- `i_req`  in  1  fetch request valid.
- `o_rdata`  out  32  instruction word; valid when `o_hit`=1.
- `o_hit`  out  1  combinational: `i_req` and a valid tag match in the indexed set.
- `i_flush`  in  1  one-cycle pulse; invalidate all lines.
- `o_mem_req`  out  1  refill word read request.
- `o_mem_addr`  out  32  word address of the refill read.
- `i_mem_rdata`  in  32  refill data.
- `i_mem_vd`  in  1  refill data valid; consumes the current request.
- `o_busy`  out  1  FSM not in IDLE.
- `o_miss_count`  out  32  count of refills started; saturates at 0xFFFF_FFFF.

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS*4) low bits; word select = `i_addr`[OFF-1:2].
  - IDX = log2(SETS) bits above OFF.
  - Tag = the remaining upper bits.
- Storage:
  - Valid and tag arrays in flops.
  - Data array read asynchronously (LUT RAM or flops), written synchronously.
  - One round-robin victim pointer per set, log2(WAYS) bits wide (zero-width is allowed when WAYS=1).
- Reset (`rst`=0, asynchronous):
  - All valid bits 0, victim pointers 0, FSM IDLE, word counter 0.
  - `o_mem_req`=0, `o_mem_addr`=0, `o_busy`=0, `o_miss_count`=0.
  - Consequently `o_hit`=0.
- `o_hit`/`o_rdata` are purely combinational from `i_addr` and the arrays, in any FSM state.
  - `o_rdata` is the word from the matching way.
  - `o_rdata`=0 when there is no hit.
  - At most one way may match; the refill invalidates the victim way before writing it, which guarantees this.
- FSM states: IDLE, REFILL, DONE.
  - IDLE → REFILL when `i_req`=1, `o_hit`=0 and `i_flush`=0. On this transition:
    - Latch the line base (`i_addr` with offset bits cleared), index and tag.
    - Victim = lowest-numbered invalid way in the set, else the set's pointer.
    - Clear the victim's valid bit.
    - Increment `o_miss_count`.
    - Counter k=0.
  - REFILL:
    - `o_mem_req`=1 and `o_mem_addr` = base + 4*k, both registered; the first request appears the cycle after the miss is detected.
    - On `i_mem_vd`=1: write `i_mem_rdata` into victim word k, then k=k+1.
    - When k=LINE_WORDS-1 and `i_mem_vd`=1: `o_mem_req` goes to 0 next cycle and the FSM moves to DONE.
    - `i_mem_vd` while `o_mem_req`=0 is ignored.
  - DONE (1 cycle):
    - Set valid, write the tag.
    - If the victim was the pointer's way, advance the set's pointer (mod WAYS).
    - Return to IDLE. `o_hit` for that line goes to 1 in the following cycle.
- Miss latency: 1 (request issue) + LINE_WORDS memory handshakes + 1 (DONE) cycles, plus memory wait states.
- `i_addr` changes during REFILL: the refill completes for the latched line. `o_hit` tracks the current `i_addr` (hits in other lines are served).
- Hits do not update the victim pointer (round-robin replacement, not LRU).
- `i_flush` has priority over everything:
  - Next cycle: all valid bits 0, pointers 0, FSM IDLE, `o_mem_req`=0.
  - An in-flight refill is aborted and its line stays invalid.
  - Late `i_mem_vd` after the abort is ignored.
- `o_miss_count` holds at 0xFFFF_FFFF and does not wrap.

Test Plan:
- Reset then `i_req`=1, `i_addr`=0x100 (defaults): `o_hit`=0. Next cycle `o_mem_req`=1, `o_mem_addr`=0x100, then 0x104, 0x108, 0x10C as the memory returns 0xA0..0xA3 with `i_mem_vd`=1 each cycle. `o_hit`=1 and `o_rdata`=0xA2 for `i_addr`=0x108 after DONE; `o_miss_count`=1.
- Two-way fill then evict: with 0x100 loaded, miss at 0x200 (same index 0) fills way1, then miss at 0x300 evicts way0. Required: 0x100 misses, 0x200 hits, 0x300 hits, `o_miss_count`=3.
- Memory wait states: insert 3 idle cycles between `i_mem_vd` pulses. Required: `o_mem_addr` holds each word address until its `i_mem_vd`; the line is correct, with no duplicate or skipped words.
- Flush mid-refill: flush after word 1 of the 0x400 refill. Required: `o_mem_req`=0 and `o_busy`=0 next cycle. All previously hitting lines miss afterwards. A stray `i_mem_vd` writes nothing.
- Hit under refill: during the 0x200 refill, present `i_addr`=0x104 (cached). Required: `o_hit`=1 and `o_rdata`=0xA1 in the same cycle, and the refill continues unaffected.
- Async reset: assert `rst`=0 mid-refill, between clock edges. Required: outputs reset immediately (`o_mem_req`=0, `o_busy`=0, `o_hit`=0); after release, the first access to 0x100 misses.
